perf_event_monitor: RTL and testbench
=====================================

// Module: perf_event_monitor
// PURPOSE
//  Synthesizable per-cycle performance monitor for the pipelined processor.
//  - Replaces bench-only instruction/cache counting with hardware counters.
//  - Counts a free-running cycle count plus NUM_EVENTS single-bit event channels
//    (retire, I$ req/hit, D$ req/hit, stall, ...).
//  - Freezes all counts on halt; counters are read back through a registered select port.
// PARAMETERS
//  NUM_EVENTS  6  number of event channels (1..16)
//  CNT_W       32 width of every counter, cycle counter included (8..64)
//  SATURATE    1  1: counters stick at all-ones; 0: counters wrap to 0
//  SEL_W       4  width of rd_sel; must satisfy 2**SEL_W >= NUM_EVENTS+1
// PORTS
//  clk        in   1           processor clock
//  rst        in   1           asynchronous reset, active-high
//  enable     in   1           counting enable (gated with ~frozen)
//  clear      in   1           synchronous clear of all counters and flags
//  event_in   in   NUM_EVENTS  per-cycle event pulses, bit i = channel i
//  halt       in   1           halt reached the memory/writeback stage
//  rd_req     in   1           readout request
//  rd_sel     in   SEL_W       0 = cycle counter; k = event channel k-1
//  rd_valid   out  1           rd_data is valid (one-cycle pulse)
//  rd_data    out  CNT_W       selected counter value
//  frozen     out  1           counting stopped by halt
//  ovf        out  NUM_EVENTS+1 sticky overflow; bit 0 = cycle counter, bit k = channel k-1
// BEHAVIOUR
//  Reset: all counters = 0, rd_valid = 0, rd_data = 0, frozen = 0, ovf = 0.
//  Count condition: run = enable & ~frozen & ~clear.
//  - On each clk with run = 1: cycle counter += 1; channel i += event_in[i].
//  Overflow: an increment from all-ones sets the ovf bit (sticky).
//  - SATURATE=1: value holds at all-ones.
//  - SATURATE=0: value wraps to 0.
//  Halt:
//  - halt=1 with run=1: that cycle's events and cycle are still counted.
//  - frozen=1 from the next cycle onward. Further halt pulses have no effect.
//  clear=1 (priority over counting and halt):
//  - next cycle all counters = 0, ovf = 0, frozen = 0.
//  - halt in the same cycle as clear is ignored.
//  Readout:
//  - rd_req sampled at clk edge n; at edge n+1 rd_valid=1 and rd_data = the value
//    of the selected counter as it stood after edge n (i.e. pre-update at edge n).
//  - One request per cycle may be back-to-back; each request is answered exactly once.
//  - rd_sel > NUM_EVENTS returns 0 with rd_valid=1.
//  - rd_valid deasserts the cycle after a request-free cycle. rd_data holds its
//    last value when rd_valid=0.
//  - A request in the same cycle as clear returns the pre-clear value.
//  Reset asserted mid-run: everything returns to reset values immediately (async);
//  an in-flight read is dropped (no rd_valid).
//  Widths: all arithmetic is unsigned CNT_W; no sign handling.
// STRUCTURE
//  perf_pkg:
//  - event index constants EV_RETIRE=0, EV_ICREQ=1, EV_ICHIT=2, EV_DCREQ=3,
//    EV_DCHIT=4, EV_STALL=5.
//  - SEL_CYCLE=0.
//  perf_counter_cell:
//  - one counter plus its sticky ovf bit, with parameters CNT_W and SATURATE.
//  - ports: clk, rst, clr, inc, cnt, ovf.
//  - instantiated NUM_EVENTS+1 times via generate.
//  Top level: run/freeze control and the readout mux/register.
// TESTING
//  1. Reset, enable=1, event_in=6'b000001 for 10 cycles, halt on cycle 10
//     -> cycle=10, ch0=10, frozen=1; 5 more cycles leave both unchanged.
//  2. CNT_W=8, SATURATE=1, ch1 pulsed 300 cycles -> ch1=8'hFF, ovf[2]=1.
//     Same with SATURATE=0 -> ch1=300 mod 256 = 44, ovf[2]=1.
//  3. clear and halt in the same cycle after 7 counted cycles
//     -> all counters=0, frozen=0, ovf=0; counting resumes the next cycle.
//  4. Back-to-back rd_req with rd_sel=0,1,7 (NUM_EVENTS=6) -> three consecutive
//     rd_valid pulses carrying cycle, ch0, 0; then rd_valid=0.
//  5. rst asserted mid-count between edges, with rd_req pending
//     -> outputs zero immediately, no rd_valid after release.
//  6. enable=0 with events active for 4 cycles -> no counter changes;
//     re-enabling resumes from the held values.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance event monitor: event channel indices
// and the readout select encoding (select 0 is the cycle counter).
package perf_pkg;

  localparam int EV_RETIRE = 0;
  localparam int EV_ICREQ  = 1;
  localparam int EV_ICHIT  = 2;
  localparam int EV_DCREQ  = 3;
  localparam int EV_DCHIT  = 4;
  localparam int EV_STALL  = 5;

  localparam int SEL_CYCLE = 0;

  // Event channel i lives one slot above the cycle counter.
  function automatic int selForEvent(input int ev);
    return ev + SEL_CYCLE + 1;
  endfunction

endpackage

// File: rtl/perf_event_monitor_if.sv
// Control, event and readout bundle of the performance monitor; the master
// side drives events and requests, the slave side is the monitor itself.
interface perf_event_monitor_if #(
  parameter int NUM_EVENTS = 6,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = 4
);

  logic                  enable;
  logic                  clear;
  logic [NUM_EVENTS-1:0] event_in;
  logic                  halt;
  logic                  rd_req;
  logic [SEL_W-1:0]      rd_sel;
  logic                  rd_valid;
  logic [CNT_W-1:0]      rd_data;
  logic                  frozen;
  logic [NUM_EVENTS:0]   ovf;

  modport master (
    output enable, clear, event_in, halt, rd_req, rd_sel,
    input  rd_valid, rd_data, frozen, ovf
  );

  modport slave (
    input  enable, clear, event_in, halt, rd_req, rd_sel,
    output rd_valid, rd_data, frozen, ovf
  );

endinterface

// File: rtl/perf_counter_cell.sv
// One performance counter with a sticky overflow flag; on overflow it either
// sticks at all-ones or wraps to zero depending on SATURATE.
module perf_counter_cell #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Per-cycle performance monitor: a cycle counter plus NUM_EVENTS event
// counters, frozen by halt, read back through a registered select port.
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 6,
  parameter int CNT_W      = 32,
  parameter bit SATURATE   = 1'b1,
  parameter int SEL_W      = 4
) (
  input logic                 clk,
  input logic                 rst,
  perf_event_monitor_if.slave mon
);

  localparam int NCNT = NUM_EVENTS + 1;

  logic             run;
  logic [NCNT-1:0]  incVec;
  logic [NCNT-1:0]  ovfVec;
  logic [CNT_W-1:0] cntArr [NCNT];
  logic [CNT_W-1:0] rdMux;
  logic             frozen_q, frozen_d;
  logic             rdValid_q;
  logic [CNT_W-1:0] rdData_q, rdData_d;

  // Clear wins over counting, so a cleared cycle neither counts nor freezes.
  assign run = mon.enable & ~frozen_q & ~mon.clear;

  always_comb begin
    incVec            = '0;
    incVec[SEL_CYCLE] = run;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      incVec[selForEvent(i)] = run & mon.event_in[i];
    end
  end

  generate
    for (genvar k = 0; k < NCNT; k++) begin : g_cell
      perf_counter_cell #(
        .CNT_W    (CNT_W),
        .SATURATE (SATURATE)
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .clr (mon.clear),
        .inc (incVec[k]),
        .cnt (cntArr[k]),
        .ovf (ovfVec[k])
      );
    end
  endgenerate

  // Unpopulated select codes fall through to zero.
  always_comb begin
    rdMux = '0;
    for (int k = 0; k < NCNT; k++) begin
      if (mon.rd_sel == SEL_W'(k)) begin
        rdMux = cntArr[k];
      end
    end
  end

  always_comb begin
    frozen_d = mon.clear ? 1'b0 : (frozen_q | (run & mon.halt));
    rdData_d = mon.rd_req ? rdMux : rdData_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen_q  <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      frozen_q  <= frozen_d;
      rdValid_q <= mon.rd_req;
      rdData_q  <= rdData_d;
    end
  end

  assign mon.rd_valid = rdValid_q;
  assign mon.rd_data  = rdData_q;
  assign mon.frozen   = frozen_q;
  assign mon.ovf      = ovfVec;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Directed bench for perf_event_monitor: a 32-bit saturating instance for the
// main scenarios plus 8-bit saturating and wrapping instances for overflow.
module tb_perf_event_monitor;
  import perf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  always #5 clk = ~clk;

  perf_event_monitor_if #(.NUM_EVENTS(6), .CNT_W(32), .SEL_W(4)) monIf ();
  perf_event_monitor_if #(.NUM_EVENTS(6), .CNT_W(8),  .SEL_W(4)) satIf ();
  perf_event_monitor_if #(.NUM_EVENTS(6), .CNT_W(8),  .SEL_W(4)) wrapIf ();

  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(32), .SATURATE(1'b1), .SEL_W(4)) dut (
    .clk (clk), .rst (rst), .mon (monIf)
  );
  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b1), .SEL_W(4)) dutSat (
    .clk (clk), .rst (rst), .mon (satIf)
  );
  perf_event_monitor #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b0), .SEL_W(4)) dutWrap (
    .clk (clk), .rst (rst), .mon (wrapIf)
  );

  typedef struct {
    logic        en;
    logic [5:0]  ev;
    int          cycles;
    logic [3:0]  sel;
    logic [31:0] expData;
    string       name;
  } vector_t;

  vector_t vecTable [11];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic [5:0] ev,
                               input logic hlt, input logic req, input logic [3:0] sel);
    monIf.enable   = en;
    monIf.clear    = clr;
    monIf.event_in = ev;
    monIf.halt     = hlt;
    monIf.rd_req   = req;
    monIf.rd_sel   = sel;
  endtask

  task automatic readMain(input logic [3:0] sel, input string name, input logic [31:0] expData);
    monIf.rd_req = 1'b1;
    monIf.rd_sel = sel;
    tick(1);
    checkOutput({name, " valid"}, 64'(monIf.rd_valid), 64'd1);
    checkOutput(name, 64'(monIf.rd_data), 64'(expData));
    monIf.rd_req = 1'b0;
  endtask

  task automatic readSmall(input logic [3:0] sel, input string name,
                           input logic [7:0] expSat, input logic [7:0] expWrap);
    satIf.rd_req  = 1'b1;
    satIf.rd_sel  = sel;
    wrapIf.rd_req = 1'b1;
    wrapIf.rd_sel = sel;
    tick(1);
    checkOutput({name, " sat valid"}, 64'(satIf.rd_valid), 64'd1);
    checkOutput({name, " sat"}, 64'(satIf.rd_data), 64'(expSat));
    checkOutput({name, " wrap"}, 64'(wrapIf.rd_data), 64'(expWrap));
    satIf.rd_req  = 1'b0;
    wrapIf.rd_req = 1'b0;
  endtask

  task automatic idleSmall();
    satIf.enable = 1'b0;  satIf.clear = 1'b0;  satIf.event_in = '0;
    satIf.halt   = 1'b0;  satIf.rd_req = 1'b0; satIf.rd_sel   = '0;
    wrapIf.enable = 1'b0; wrapIf.clear = 1'b0;  wrapIf.event_in = '0;
    wrapIf.halt   = 1'b0; wrapIf.rd_req = 1'b0; wrapIf.rd_sel   = '0;
  endtask

  initial begin
    // Cumulative directed table, starting from cleared counters.
    vecTable[0]  = '{1'b1, 6'b000011, 5, 4'd0,  32'd5,  "tbl cycle after 5"};
    vecTable[1]  = '{1'b1, 6'b101010, 3, 4'd2,  32'd8,  "tbl icreq after 8"};
    vecTable[2]  = '{1'b0, 6'b111111, 4, 4'd0,  32'd8,  "tbl cycle held en=0"};
    vecTable[3]  = '{1'b0, 6'b111111, 1, 4'd6,  32'd3,  "tbl stall held en=0"};
    vecTable[4]  = '{1'b1, 6'b100000, 2, 4'd6,  32'd5,  "tbl stall resumed"};
    vecTable[5]  = '{1'b1, 6'b000000, 4, 4'd1,  32'd5,  "tbl retire idle"};
    vecTable[6]  = '{1'b0, 6'b000000, 1, 4'd0,  32'd14, "tbl cycle 14"};
    vecTable[7]  = '{1'b0, 6'b000000, 1, 4'd15, 32'd0,  "tbl sel out of range"};
    vecTable[8]  = '{1'b1, 6'b010100, 6, 4'd5,  32'd6,  "tbl dchit"};
    vecTable[9]  = '{1'b0, 6'b000000, 1, 4'd3,  32'd6,  "tbl ichit"};
    vecTable[10] = '{1'b0, 6'b000000, 1, 4'd4,  32'd3,  "tbl dcreq"};

    applyStimulus(1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 4'd0);
    idleSmall();

    // Reset state
    tick(2);
    checkOutput("reset rd_valid", 64'(monIf.rd_valid), 64'd0);
    checkOutput("reset rd_data", 64'(monIf.rd_data), 64'd0);
    checkOutput("reset frozen", 64'(monIf.frozen), 64'd0);
    checkOutput("reset ovf", 64'(monIf.ovf), 64'd0);
    rst = 1'b0;
    tick(1);
    readMain(4'(SEL_CYCLE), "reset cycle count", 32'd0);

    // Retire for 10 cycles, halt on the 10th, then stay frozen
    applyStimulus(1'b1, 1'b0, 6'b000001, 1'b0, 1'b0, 4'd0);
    tick(9);
    monIf.halt = 1'b1;
    tick(1);
    monIf.halt = 1'b0;
    checkOutput("frozen after halt", 64'(monIf.frozen), 64'd1);
    readMain(4'(SEL_CYCLE), "halt cycle", 32'd10);
    readMain(4'(selForEvent(EV_RETIRE)), "halt retire", 32'd10);
    tick(5);
    readMain(4'(SEL_CYCLE), "frozen cycle", 32'd10);
    readMain(4'(selForEvent(EV_RETIRE)), "frozen retire", 32'd10);
    readMain(4'(selForEvent(EV_ICREQ)), "frozen icreq", 32'd0);
    checkOutput("still frozen", 64'(monIf.frozen), 64'd1);

    // Clear unfreezes; then clear and halt together after 7 counted cycles
    applyStimulus(1'b0, 1'b1, 6'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    monIf.clear = 1'b0;
    checkOutput("unfrozen by clear", 64'(monIf.frozen), 64'd0);
    applyStimulus(1'b1, 1'b0, 6'b111111, 1'b0, 1'b0, 4'd0);
    tick(7);
    applyStimulus(1'b1, 1'b1, 6'b111111, 1'b1, 1'b1, 4'(selForEvent(EV_ICHIT)));
    tick(1);
    checkOutput("clear read valid", 64'(monIf.rd_valid), 64'd1);
    checkOutput("clear read pre-clear value", 64'(monIf.rd_data), 64'd7);
    checkOutput("clear+halt frozen", 64'(monIf.frozen), 64'd0);
    checkOutput("clear ovf", 64'(monIf.ovf), 64'd0);
    applyStimulus(1'b1, 1'b0, 6'b000001, 1'b0, 1'b0, 4'd0);
    tick(3);
    monIf.enable = 1'b0;
    readMain(4'(SEL_CYCLE), "post-clear cycle", 32'd3);
    readMain(4'(selForEvent(EV_RETIRE)), "post-clear retire", 32'd3);
    readMain(4'(selForEvent(EV_ICREQ)), "post-clear icreq", 32'd0);

    // Table-driven vectors
    applyStimulus(1'b0, 1'b1, 6'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    monIf.clear = 1'b0;
    for (int i = 0; i < 11; i++) begin
      monIf.enable   = vecTable[i].en;
      monIf.event_in = vecTable[i].ev;
      tick(vecTable[i].cycles);
      monIf.enable   = 1'b0;
      monIf.event_in = '0;
      readMain(vecTable[i].sel, vecTable[i].name, vecTable[i].expData);
    end

    // Back-to-back reads 0, 1, 7 (cycle=20, retire=5)
    applyStimulus(1'b0, 1'b0, 6'b0, 1'b0, 1'b1, 4'd0);
    tick(1);
    checkOutput("b2b #1 valid", 64'(monIf.rd_valid), 64'd1);
    checkOutput("b2b #1 data", 64'(monIf.rd_data), 64'd20);
    monIf.rd_sel = 4'd1;
    tick(1);
    checkOutput("b2b #2 valid", 64'(monIf.rd_valid), 64'd1);
    checkOutput("b2b #2 data", 64'(monIf.rd_data), 64'd5);
    monIf.rd_sel = 4'd7;
    tick(1);
    checkOutput("b2b #3 valid", 64'(monIf.rd_valid), 64'd1);
    checkOutput("b2b #3 data", 64'(monIf.rd_data), 64'd0);
    monIf.rd_req = 1'b0;
    tick(1);
    checkOutput("b2b idle valid", 64'(monIf.rd_valid), 64'd0);
    readMain(4'd1, "hold setup", 32'd5);
    tick(2);
    checkOutput("hold valid low", 64'(monIf.rd_valid), 64'd0);
    checkOutput("hold data", 64'(monIf.rd_data), 64'd5);

    // 8-bit counters across the all-ones boundary
    satIf.enable = 1'b1;   satIf.event_in  = 6'b000010;
    wrapIf.enable = 1'b1;  wrapIf.event_in = 6'b000010;
    tick(255);
    checkOutput("sat ovf at 255", 64'(satIf.ovf), 64'd0);
    checkOutput("wrap ovf at 255", 64'(wrapIf.ovf), 64'd0);
    tick(45);
    satIf.enable = 1'b0;   satIf.event_in  = '0;
    wrapIf.enable = 1'b0;  wrapIf.event_in = '0;
    checkOutput("sat ovf at 300", 64'(satIf.ovf), 64'h05);
    checkOutput("wrap ovf at 300", 64'(wrapIf.ovf), 64'h05);
    readSmall(4'(selForEvent(EV_ICREQ)), "small icreq", 8'hFF, 8'd44);
    readSmall(4'(SEL_CYCLE), "small cycle", 8'hFF, 8'd44);
    readSmall(4'(selForEvent(EV_RETIRE)), "small retire", 8'd0, 8'd0);

    // Async reset mid-cycle with a read in flight
    applyStimulus(1'b1, 1'b0, 6'b111111, 1'b0, 1'b0, 4'd0);
    tick(3);
    monIf.rd_req = 1'b1;
    tick(1);
    checkOutput("pre-reset read data", 64'(monIf.rd_data), 64'd23);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async reset rd_valid", 64'(monIf.rd_valid), 64'd0);
    checkOutput("async reset rd_data", 64'(monIf.rd_data), 64'd0);
    checkOutput("async reset ovf", 64'(satIf.ovf), 64'd0);
    applyStimulus(1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("post-reset rd_valid #1", 64'(monIf.rd_valid), 64'd0);
    tick(1);
    checkOutput("post-reset rd_valid #2", 64'(monIf.rd_valid), 64'd0);
    readMain(4'(SEL_CYCLE), "post-reset cycle", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
